// File: rtl/csr_issue_ctrl.sv
// csr_issue_ctrl: single-entry serialising issue controller for the CSR unit.
// Holds one CSR instruction until it reaches the ROB head, issues it once,
// captures the combinational response and hands it back to the RCU.
module csr_issue_ctrl #(
  parameter int ROB_INDEX_WIDTH       = 4,
  parameter int PHY_REG_ADDR_WIDTH    = 6,
  parameter int XLEN                  = 64,
  parameter int IMM_LEN               = 5,
  parameter int CSR_ADDR_LEN          = 12,
  parameter int EXCEPTION_CAUSE_WIDTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  // request from RCU
  input  logic                             rcu_ctrl_req_valid_i,
  output logic                             rcu_ctrl_req_ready_o,
  input  logic [ROB_INDEX_WIDTH-1:0]       rob_index_i,
  input  logic [PHY_REG_ADDR_WIDTH-1:0]    prd_addr_i,
  input  logic [2:0]                       func3_i,
  input  logic [XLEN-1:0]                  prs1_data_i,
  input  logic [IMM_LEN-1:0]               imm_i,
  input  logic [CSR_ADDR_LEN-1:0]          csr_addr_i,
  input  logic                             csr_do_read_i,
  input  logic                             csr_do_write_i,
  input  logic [ROB_INDEX_WIDTH-1:0]       rob_head_index_i,
  input  logic                             flush_i,
  // request to CSR unit
  output logic                             ctrl_csr_req_valid_o,
  output logic [ROB_INDEX_WIDTH-1:0]       ctrl_rob_index_o,
  output logic [PHY_REG_ADDR_WIDTH-1:0]    ctrl_prd_addr_o,
  output logic [2:0]                       ctrl_func3_o,
  output logic [XLEN-1:0]                  ctrl_prs1_data_o,
  output logic [IMM_LEN-1:0]               ctrl_imm_o,
  output logic [CSR_ADDR_LEN-1:0]          ctrl_csr_addr_o,
  output logic                             ctrl_csr_do_read_o,
  output logic                             ctrl_csr_do_write_o,
  // response from CSR unit
  input  logic                             csr_resp_valid_i,
  input  logic [ROB_INDEX_WIDTH-1:0]       csr_wrb_rob_index_i,
  input  logic [PHY_REG_ADDR_WIDTH-1:0]    csr_wrb_addr_i,
  input  logic [XLEN-1:0]                  csr_wrb_data_i,
  input  logic                             csr_exception_i,
  input  logic [EXCEPTION_CAUSE_WIDTH-1:0] csr_ecause_i,
  // writeback to RCU
  output logic                             wb_valid_o,
  input  logic                             wb_ready_i,
  output logic [ROB_INDEX_WIDTH-1:0]       wb_rob_index_o,
  output logic [PHY_REG_ADDR_WIDTH-1:0]    wb_addr_o,
  output logic [XLEN-1:0]                  wb_data_o,
  output logic                             wb_exception_o,
  output logic [EXCEPTION_CAUSE_WIDTH-1:0] wb_ecause_o,
  output logic                             csr_busy_o
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_HEAD = 2'd1,
    ISSUE     = 2'd2,
    WRB       = 2'd3
  } state_e;

  state_e state, state_next;

  // captured request payload
  logic [ROB_INDEX_WIDTH-1:0]       rob_index_q;
  logic [PHY_REG_ADDR_WIDTH-1:0]    prd_addr_q;
  logic [2:0]                       func3_q;
  logic [XLEN-1:0]                  prs1_data_q;
  logic [IMM_LEN-1:0]               imm_q;
  logic [CSR_ADDR_LEN-1:0]          csr_addr_q;
  logic                             csr_do_read_q;
  logic                             csr_do_write_q;

  // captured writeback payload
  logic [ROB_INDEX_WIDTH-1:0]       wb_rob_index_q;
  logic [PHY_REG_ADDR_WIDTH-1:0]    wb_addr_q;
  logic [XLEN-1:0]                  wb_data_q;
  logic                             wb_exception_q;
  logic [EXCEPTION_CAUSE_WIDTH-1:0] wb_ecause_q;

  logic accept;
  logic resp_capture;

  assign accept       = rcu_ctrl_req_valid_i & rcu_ctrl_req_ready_o;
  // a flushed ISSUE must not latch a response that belongs to a dropped entry
  assign resp_capture = (state == ISSUE) & csr_resp_valid_i & ~flush_i;

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic; flush overrides every transition.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_next unassigned,
    // which would otherwise infer a latch.
    state_next = state;
    case (state)
      IDLE:      if (accept)                             state_next = WAIT_HEAD;
      WAIT_HEAD: if (rob_index_q == rob_head_index_i)    state_next = ISSUE;
      ISSUE:     if (csr_resp_valid_i)                   state_next = WRB;
      WRB:       if (wb_ready_i)                         state_next = IDLE;
      default:                                           state_next = IDLE;
    endcase
    if (flush_i) state_next = IDLE;
  end

  // Handshake and status outputs decoded from the current state.
  always_comb begin
    rcu_ctrl_req_ready_o = 1'b0;
    ctrl_csr_req_valid_o = 1'b0;
    wb_valid_o           = 1'b0;
    csr_busy_o           = (state != IDLE);
    case (state)
      IDLE:    rcu_ctrl_req_ready_o = ~flush_i;
      ISSUE:   ctrl_csr_req_valid_o = ~flush_i;
      WRB:     wb_valid_o           = 1'b1;
      default: ;
    endcase
  end

  // Request payload capture on the RCU handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      rob_index_q    <= '0;
      prd_addr_q     <= '0;
      func3_q        <= '0;
      prs1_data_q    <= '0;
      imm_q          <= '0;
      csr_addr_q     <= '0;
      csr_do_read_q  <= 1'b0;
      csr_do_write_q <= 1'b0;
    end else if (accept) begin
      rob_index_q    <= rob_index_i;
      prd_addr_q     <= prd_addr_i;
      func3_q        <= func3_i;
      prs1_data_q    <= prs1_data_i;
      imm_q          <= imm_i;
      csr_addr_q     <= csr_addr_i;
      csr_do_read_q  <= csr_do_read_i;
      csr_do_write_q <= csr_do_write_i;
    end
  end

  // Writeback payload capture from the combinational CSR response.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_rob_index_q <= '0;
      wb_addr_q      <= '0;
      wb_data_q      <= '0;
      wb_exception_q <= 1'b0;
      wb_ecause_q    <= '0;
    end else if (resp_capture) begin
      wb_rob_index_q <= csr_wrb_rob_index_i;
      wb_addr_q      <= csr_wrb_addr_i;
      wb_data_q      <= csr_wrb_data_i;
      wb_exception_q <= csr_exception_i;
      wb_ecause_q    <= csr_ecause_i;
    end
  end

  assign ctrl_rob_index_o    = rob_index_q;
  assign ctrl_prd_addr_o     = prd_addr_q;
  assign ctrl_func3_o        = func3_q;
  assign ctrl_prs1_data_o    = prs1_data_q;
  assign ctrl_imm_o          = imm_q;
  assign ctrl_csr_addr_o     = csr_addr_q;
  assign ctrl_csr_do_read_o  = csr_do_read_q;
  assign ctrl_csr_do_write_o = csr_do_write_q;

  assign wb_rob_index_o = wb_rob_index_q;
  assign wb_addr_o      = wb_addr_q;
  assign wb_data_o      = wb_data_q;
  assign wb_exception_o = wb_exception_q;
  assign wb_ecause_o    = wb_ecause_q;

endmodule

// File: tb/tb_csr_issue_ctrl.sv
// Directed testbench for csr_issue_ctrl. Inputs change just after the falling
// edge; outputs are sampled 1 ns later, well away from the rising edge.
module tb_csr_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        rcu_ctrl_req_valid_i;
  logic        rcu_ctrl_req_ready_o;
  logic [3:0]  rob_index_i;
  logic [5:0]  prd_addr_i;
  logic [2:0]  func3_i;
  logic [63:0] prs1_data_i;
  logic [4:0]  imm_i;
  logic [11:0] csr_addr_i;
  logic        csr_do_read_i;
  logic        csr_do_write_i;
  logic [3:0]  rob_head_index_i;
  logic        flush_i;
  logic        ctrl_csr_req_valid_o;
  logic [3:0]  ctrl_rob_index_o;
  logic [5:0]  ctrl_prd_addr_o;
  logic [2:0]  ctrl_func3_o;
  logic [63:0] ctrl_prs1_data_o;
  logic [4:0]  ctrl_imm_o;
  logic [11:0] ctrl_csr_addr_o;
  logic        ctrl_csr_do_read_o;
  logic        ctrl_csr_do_write_o;
  logic        csr_resp_valid_i;
  logic [3:0]  csr_wrb_rob_index_i;
  logic [5:0]  csr_wrb_addr_i;
  logic [63:0] csr_wrb_data_i;
  logic        csr_exception_i;
  logic [3:0]  csr_ecause_i;
  logic        wb_valid_o;
  logic        wb_ready_i;
  logic [3:0]  wb_rob_index_o;
  logic [5:0]  wb_addr_o;
  logic [63:0] wb_data_o;
  logic        wb_exception_o;
  logic [3:0]  wb_ecause_o;
  logic        csr_busy_o;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  csr_issue_ctrl dut (
    .clk                  (clk),
    .rst                  (rst),
    .rcu_ctrl_req_valid_i (rcu_ctrl_req_valid_i),
    .rcu_ctrl_req_ready_o (rcu_ctrl_req_ready_o),
    .rob_index_i          (rob_index_i),
    .prd_addr_i           (prd_addr_i),
    .func3_i              (func3_i),
    .prs1_data_i          (prs1_data_i),
    .imm_i                (imm_i),
    .csr_addr_i           (csr_addr_i),
    .csr_do_read_i        (csr_do_read_i),
    .csr_do_write_i       (csr_do_write_i),
    .rob_head_index_i     (rob_head_index_i),
    .flush_i              (flush_i),
    .ctrl_csr_req_valid_o (ctrl_csr_req_valid_o),
    .ctrl_rob_index_o     (ctrl_rob_index_o),
    .ctrl_prd_addr_o      (ctrl_prd_addr_o),
    .ctrl_func3_o         (ctrl_func3_o),
    .ctrl_prs1_data_o     (ctrl_prs1_data_o),
    .ctrl_imm_o           (ctrl_imm_o),
    .ctrl_csr_addr_o      (ctrl_csr_addr_o),
    .ctrl_csr_do_read_o   (ctrl_csr_do_read_o),
    .ctrl_csr_do_write_o  (ctrl_csr_do_write_o),
    .csr_resp_valid_i     (csr_resp_valid_i),
    .csr_wrb_rob_index_i  (csr_wrb_rob_index_i),
    .csr_wrb_addr_i       (csr_wrb_addr_i),
    .csr_wrb_data_i       (csr_wrb_data_i),
    .csr_exception_i      (csr_exception_i),
    .csr_ecause_i         (csr_ecause_i),
    .wb_valid_o           (wb_valid_o),
    .wb_ready_i           (wb_ready_i),
    .wb_rob_index_o       (wb_rob_index_o),
    .wb_addr_o            (wb_addr_o),
    .wb_data_o            (wb_data_o),
    .wb_exception_o       (wb_exception_o),
    .wb_ecause_o          (wb_ecause_o),
    .csr_busy_o           (csr_busy_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // advance to the next low phase; inputs may then be changed
  task automatic next_cycle();
    @(negedge clk);
  endtask

  // let combinational outputs settle before sampling
  task automatic settle();
    #1;
  endtask

  task automatic offer(input logic [3:0] rob, input logic [5:0] prd, input logic [2:0] f3,
                       input logic [63:0] rs1, input logic [11:0] addr);
    rcu_ctrl_req_valid_i = 1'b1;
    rob_index_i          = rob;
    prd_addr_i           = prd;
    func3_i              = f3;
    prs1_data_i          = rs1;
    imm_i                = 5'd0;
    csr_addr_i           = addr;
    csr_do_read_i        = 1'b1;
    csr_do_write_i       = 1'b1;
  endtask

  task automatic respond(input logic [3:0] rob, input logic [5:0] addr, input logic [63:0] data,
                         input logic exc, input logic [3:0] cause);
    csr_resp_valid_i    = 1'b1;
    csr_wrb_rob_index_i = rob;
    csr_wrb_addr_i      = addr;
    csr_wrb_data_i      = data;
    csr_exception_i     = exc;
    csr_ecause_i        = cause;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    rcu_ctrl_req_valid_i = 1'b0;
    rob_index_i = '0; prd_addr_i = '0; func3_i = '0; prs1_data_i = '0;
    imm_i = '0; csr_addr_i = '0; csr_do_read_i = 1'b0; csr_do_write_i = 1'b0;
    rob_head_index_i = '0; flush_i = 1'b0;
    csr_resp_valid_i = 1'b0; csr_wrb_rob_index_i = '0; csr_wrb_addr_i = '0;
    csr_wrb_data_i = '0; csr_exception_i = 1'b0; csr_ecause_i = '0;
    wb_ready_i = 1'b1;

    // ---------------- reset state
    next_cycle(); next_cycle();
    rst = 1'b0;
    settle();
    check("rst_ready",     rcu_ctrl_req_ready_o, 1);
    check("rst_req_valid", ctrl_csr_req_valid_o, 0);
    check("rst_wb_valid",  wb_valid_o, 0);
    check("rst_busy",      csr_busy_o, 0);
    check("rst_ctrl_prs1", ctrl_prs1_data_o, 0);
    check("rst_wb_data",   wb_data_o, 0);

    // ---------------- basic CSRRW, head already matching
    next_cycle();                                       // T
    rob_head_index_i = 4'd3;
    offer(4'd3, 6'd7, 3'b001, 64'hDEAD, 12'h340);
    settle();
    check("t0_ready", rcu_ctrl_req_ready_o, 1);
    next_cycle();                                       // T+1 WAIT_HEAD
    rcu_ctrl_req_valid_i = 1'b0;
    settle();
    check("t1_busy",      csr_busy_o, 1);
    check("t1_req_valid", ctrl_csr_req_valid_o, 0);
    check("t1_ready",     rcu_ctrl_req_ready_o, 0);
    next_cycle();                                       // T+2 ISSUE
    respond(4'd3, 6'd7, 64'h55, 1'b0, 4'd0);
    settle();
    check("t2_req_valid", ctrl_csr_req_valid_o, 1);
    check("t2_func3",     ctrl_func3_o, 3'b001);
    check("t2_csr_addr",  ctrl_csr_addr_o, 12'h340);
    check("t2_prs1",      ctrl_prs1_data_o, 64'hDEAD);
    check("t2_rob",       ctrl_rob_index_o, 4'd3);
    check("t2_wb_valid",  wb_valid_o, 0);
    next_cycle();                                       // T+3 WRB
    csr_resp_valid_i = 1'b0;
    settle();
    check("t3_wb_valid",  wb_valid_o, 1);
    check("t3_wb_rob",    wb_rob_index_o, 4'd3);
    check("t3_wb_data",   wb_data_o, 64'h55);
    check("t3_wb_addr",   wb_addr_o, 6'd7);
    check("t3_req_valid", ctrl_csr_req_valid_o, 0);
    next_cycle();                                       // T+4 IDLE
    settle();
    check("t4_ready",    rcu_ctrl_req_ready_o, 1);
    check("t4_busy",     csr_busy_o, 0);
    check("t4_wb_valid", wb_valid_o, 0);

    // ---------------- head wait, then writeback backpressure
    rob_head_index_i = 4'd2;
    offer(4'd5, 6'd9, 3'b010, 64'h1234, 12'h300);      // T
    next_cycle();
    rcu_ctrl_req_valid_i = 1'b0;
    for (int i = 1; i <= 5; i++) begin                  // T+1..T+5
      settle();
      check("hw_req_valid_low", ctrl_csr_req_valid_o, 0);
      check("hw_ready_low",     rcu_ctrl_req_ready_o, 0);
      next_cycle();
    end
    rob_head_index_i = 4'd5;                            // T+6
    settle();
    check("hw_t6_req_valid", ctrl_csr_req_valid_o, 0);
    next_cycle();                                       // T+7 ISSUE
    respond(4'd5, 6'd9, 64'h77, 1'b0, 4'd0);
    wb_ready_i = 1'b0;
    settle();
    check("hw_t7_req_valid", ctrl_csr_req_valid_o, 1);
    check("hw_t7_func3",     ctrl_func3_o, 3'b010);
    next_cycle();                                       // WRB, stalled
    csr_resp_valid_i = 1'b0;
    csr_wrb_data_i   = 64'hBAD0;
    for (int i = 0; i < 5; i++) begin
      settle();
      check("bp_wb_valid", wb_valid_o, 1);
      check("bp_wb_data",  wb_data_o, 64'h77);
      check("bp_wb_rob",   wb_rob_index_o, 4'd5);
      check("bp_ready",    rcu_ctrl_req_ready_o, 0);
      next_cycle();
    end
    wb_ready_i = 1'b1;
    settle();
    check("bp_release_wb_valid", wb_valid_o, 1);
    next_cycle();
    settle();
    check("bp_idle_ready",    rcu_ctrl_req_ready_o, 1);
    check("bp_idle_wb_valid", wb_valid_o, 0);

    // ---------------- flush in IDLE blocks acceptance
    offer(4'd1, 6'd1, 3'b001, 64'h1, 12'h001);
    flush_i = 1'b1;
    settle();
    check("fi_ready", rcu_ctrl_req_ready_o, 0);
    next_cycle();
    rcu_ctrl_req_valid_i = 1'b0;
    flush_i = 1'b0;
    settle();
    check("fi_busy", csr_busy_o, 0);

    // ---------------- flush in WAIT_HEAD
    rob_head_index_i = 4'd0;
    offer(4'd9, 6'd3, 3'b011, 64'h99, 12'h305);
    next_cycle();                                       // WAIT_HEAD
    rcu_ctrl_req_valid_i = 1'b0;
    flush_i = 1'b1;
    settle();
    check("fw_req_valid", ctrl_csr_req_valid_o, 0);
    check("fw_busy",      csr_busy_o, 1);
    next_cycle();
    flush_i = 1'b0;
    rob_head_index_i = 4'd9;                            // would match if entry survived
    settle();
    check("fw_ready",    rcu_ctrl_req_ready_o, 1);
    check("fw_busy_low", csr_busy_o, 0);
    next_cycle();
    settle();
    check("fw_no_issue", ctrl_csr_req_valid_o, 0);
    check("fw_no_wb",    wb_valid_o, 0);

    // ---------------- flush in ISSUE, response presented the same cycle
    rob_head_index_i = 4'd4;
    offer(4'd4, 6'd4, 3'b001, 64'h44, 12'h340);
    next_cycle();                                       // WAIT_HEAD
    rcu_ctrl_req_valid_i = 1'b0;
    next_cycle();                                       // ISSUE
    settle();
    check("fs_pre_req_valid", ctrl_csr_req_valid_o, 1);
    flush_i = 1'b1;
    respond(4'd4, 6'd4, 64'hAA, 1'b0, 4'd0);
    settle();
    check("fs_req_valid_gated", ctrl_csr_req_valid_o, 0);
    next_cycle();
    flush_i = 1'b0;
    csr_resp_valid_i = 1'b0;
    settle();
    check("fs_no_wb",  wb_valid_o, 0);
    check("fs_ready",  rcu_ctrl_req_ready_o, 1);
    check("fs_busy",   csr_busy_o, 0);

    // ---------------- exception passthrough, then reset mid-WRB
    rob_head_index_i = 4'd6;
    offer(4'd6, 6'd2, 3'b001, 64'h66, 12'hFFF);
    next_cycle();                                       // WAIT_HEAD
    rcu_ctrl_req_valid_i = 1'b0;
    next_cycle();                                       // ISSUE
    respond(4'd6, 6'd2, 64'h0, 1'b1, 4'd2);
    wb_ready_i = 1'b0;
    next_cycle();                                       // WRB
    csr_resp_valid_i = 1'b0;
    settle();
    check("ex_wb_valid", wb_valid_o, 1);
    check("ex_wb_exc",   wb_exception_o, 1);
    check("ex_wb_cause", wb_ecause_o, 4'd2);
    check("ex_wb_rob",   wb_rob_index_o, 4'd6);
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    wb_ready_i = 1'b1;
    settle();
    check("mr_ready",     rcu_ctrl_req_ready_o, 1);
    check("mr_wb_valid",  wb_valid_o, 0);
    check("mr_req_valid", ctrl_csr_req_valid_o, 0);
    check("mr_busy",      csr_busy_o, 0);
    check("mr_wb_exc",    wb_exception_o, 0);
    check("mr_wb_cause",  wb_ecause_o, 0);
    check("mr_ctrl_rob",  ctrl_rob_index_o, 0);
    check("mr_ctrl_prs1", ctrl_prs1_data_o, 0);
    next_cycle();
    settle();
    check("mr_still_no_wb", wb_valid_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
